fpu_sequencer: RTL and testbench
================================

Name: fpu_sequencer

Overview:
- Sequences single-precision FP arithmetic through the shared FPU datapath and FP register file.
- Accepts one decoded FP instruction at a time over a valid/ready handshake and drives the register-file read selects and the rounding mode.
- Times the FPU's fixed per-operation latency with an internal counter, then issues one register-file write and one accrued-flags update.
- Sits between the decode stage and the FPU/FP register file, and replaces the standalone ready counter.

Parameters:
- ADDSUB_LAT, 3, FPU cycles for FADD/FSUB (>=1)
- MUL_LAT, 3, FPU cycles for FMUL (>=1)
- DIV_LAT, 12, FPU cycles for FDIV (>=1)
- CNT_W, 4, latency counter width; must hold max(LAT)-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- n_rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an FP op
- issue_ready  out  1  sequencer can accept an op
- issue_funct7  in  7  RISC-V funct7 (FADD 0000000, FSUB 0000100, FMUL 0001000, FDIV 0001100)
- issue_rs1, issue_rs2, issue_rd  in  5 each  register selects
- issue_rm  in  3  instruction rm field
- fcsr_frm  in  3  dynamic rounding mode from fcsr
- flush  in  1  synchronous kill of the in-flight op
- rf_rs1, rf_rs2  out  5 each  register-file read selects (held during EXEC)
- fpu_funct7  out  7  operation select to the FPU
- fpu_frm  out  3  resolved rounding mode to the FPU
- fpu_result  in  32  FPU result, valid on the final EXEC cycle
- fpu_flags  in  5  NV,DZ,OF,UF,NX, valid with fpu_result
- wb_en  out  1  FP register-file write strobe
- wb_rd  out  5  write destination
- wb_data  out  32  write data
- flags_we  out  1  OR flags_out into fcsr.fflags
- flags_out  out  5  flags to accrue
- illegal_op  out  1  one-cycle pulse for a rejected op
- busy  out  1  high in EXEC or WB

Behaviour:
- Reset values:
  - state=IDLE, counter=0, issue_ready=1.
  - All other outputs 0, including latched fields, wb_data and flags_out.
- States: IDLE, EXEC, WB.
- Handshake:
  - issue_ready=1 only in IDLE.
  - An op is accepted on a clock edge with issue_valid & issue_ready.
  - Fields are latched at acceptance.
  - The decoder must hold its fields while issue_valid=1 and issue_ready=0.
- Rounding-mode resolution at acceptance:
  - rm_eff = (issue_rm==3'b111) ? fcsr_frm : issue_rm.
  - rm_eff in {101,110,111} is illegal.
- An unsupported funct7 is illegal.
- Illegal op at acceptance:
  - illegal_op=1 in the following cycle.
  - State stays IDLE, with no EXEC/WB and no flags.
  - issue_ready stays 1.
- Legal op at acceptance:
  - Enter EXEC; counter loaded with LAT-1 for the op class.
  - rf_rs1/rf_rs2/fpu_funct7/fpu_frm driven from latched values for all of EXEC.
  - In IDLE these outputs hold their last values.
- EXEC:
  - Counter decrements each cycle.
  - On the cycle counter==0, sample fpu_result into wb_data and fpu_flags into flags_out, then go to WB.
- WB (exactly one cycle):
  - wb_en=1 with wb_rd=latched rd.
  - flags_we=1.
  - Next state IDLE.
- Latency: accept edge to the wb_en cycle = LAT cycles of EXEC plus 1. Throughput is one op per LAT+2 cycles; no back-to-back overlap.
- flush:
  - In EXEC or WB, forces IDLE next cycle; wb_en/flags_we deasserted that cycle; no write.
  - In IDLE, blocks acceptance that cycle (issue_ready forced 0).
  - flush has priority over counter expiry.
- Reset asserted mid-operation returns to the reset state immediately; no partial writeback.
- Flags are never cleared here; accrual/OR into fcsr is the CSR block's job.

Decomposition:
- Shared package fpu_pkg holds:
  - enum fpu_seq_state_t {IDLE,EXEC,WB}
  - localparam funct7 codes FADD/FSUB/FMUL/FDIV
  - rm codes RNE..RMM and DYN=3'b111
  - the 5-bit flag bit positions
- One natural sub-module: fpu_lat_decode (combinational). Maps funct7 to latency and an illegal bit, and resolves rm_eff with its illegal check.
- The FSM and counter stay in the top.

Test Plan:
- FADD with rs1=1, rs2=2, rd=3, rm=000:
  - rf_rs1=1 and rf_rs2=2 for 3 EXEC cycles.
  - wb_en in cycle 4 after accept, with wb_rd=3 and wb_data=fpu_result (0x40400000).
  - flags_we=1 with flags_out=00000.
- FDIV with rm=111 and fcsr_frm=010:
  - fpu_frm=010 through EXEC.
  - issue_ready=0 for 13 cycles; wb_en at cycle 13.
  - With fpu_flags=01000 (DZ), flags_out=01000.
- rm=101, or rm=111 with fcsr_frm=110:
  - illegal_op pulses once.
  - wb_en and flags_we stay 0; issue_ready stays 1.
- funct7=0101100 (FSQRT, unsupported): illegal_op=1 and no state change.
- FMUL accepted, then flush at the 2nd EXEC cycle: returns to IDLE and issue_ready=1 next cycle; wb_en never asserts.
- n_rst low during FDIV EXEC: all outputs 0 and issue_ready=1 asynchronously. A FADD issued after release completes normally in 4 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and encodings for the FP sequencer
package fpu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, WB} fpu_seq_state_t;
  localparam logic [6:0] FADD = 7'b0000000;
  localparam logic [6:0] FSUB = 7'b0000100;
  localparam logic [6:0] FMUL = 7'b0001000;
  localparam logic [6:0] FDIV = 7'b0001100;
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fpu_lat_decode.sv
// fpu_lat_decode: maps funct7 to latency-1, resolves rounding mode and flags illegal ops
module fpu_lat_decode
  import fpu_pkg::*;
#(
  parameter int ADDSUB_LAT = 3,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 12,
  parameter int CNT_W = 4
) (
  input  logic [6:0]       funct7,
  input  logic [2:0]       rm,
  input  logic [2:0]       frm,
  output logic [CNT_W-1:0] cnt_init,
  output logic [2:0]       rm_eff,
  output logic             illegal
);
  logic f7_ok;
  always_comb begin
    rm_eff = (rm == DYN) ? frm : rm;
    f7_ok = (funct7 == FADD) || (funct7 == FSUB) || (funct7 == FMUL) || (funct7 == FDIV);
    cnt_init = (funct7 == FDIV) ? CNT_W'(DIV_LAT - 1)
             : (funct7 == FMUL) ? CNT_W'(MUL_LAT - 1)
             : CNT_W'(ADDSUB_LAT - 1);
    illegal = !f7_ok || (rm_eff > RMM);
  end
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one FP op at a time, times FPU latency, then writes back result and flags
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int ADDSUB_LAT = 3,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 12,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [6:0]  issue_funct7,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic [2:0]  issue_rm,
  input  logic [2:0]  fcsr_frm,
  input  logic        flush,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [6:0]  fpu_funct7,
  output logic [2:0]  fpu_frm,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flags_we,
  output logic [4:0]  flags_out,
  output logic        illegal_op,
  output logic        busy
);
  fpu_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_init;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, flags_q, flags_d;
  logic [6:0] f7_q, f7_d;
  logic [2:0] frm_q, frm_d, rm_eff;
  logic [31:0] data_q, data_d;
  logic ill_q, ill_d, illegal, accept, legal, expire;
  fpu_lat_decode #(
    .ADDSUB_LAT(ADDSUB_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W(CNT_W)
  ) u_dec (
    .funct7(issue_funct7),
    .rm(issue_rm),
    .frm(fcsr_frm),
    .cnt_init(cnt_init),
    .rm_eff(rm_eff),
    .illegal(illegal)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      f7_q <= '0;
      frm_q <= '0;
      data_q <= '0;
      flags_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q <= rd_d;
      f7_q <= f7_d;
      frm_q <= frm_d;
      data_q <= data_d;
      flags_q <= flags_d;
      ill_q <= ill_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (legal ? EXEC : IDLE)
            : (state_q == EXEC) ? (flush ? IDLE : (cnt_q == '0) ? WB : EXEC)
            : IDLE;
  end
  always_comb begin
    accept = issue_valid && issue_ready;
    legal = accept && !illegal;
    ill_d = accept && illegal;
    expire = (state_q == EXEC) && !flush && (cnt_q == '0);
    cnt_d = legal ? cnt_init
          : (state_q == EXEC) ? ((flush || cnt_q == '0) ? '0 : cnt_q - CNT_W'(1))
          : cnt_q;
    rs1_d = legal ? issue_rs1 : rs1_q;
    rs2_d = legal ? issue_rs2 : rs2_q;
    rd_d = legal ? issue_rd : rd_q;
    f7_d = legal ? issue_funct7 : f7_q;
    frm_d = legal ? rm_eff : frm_q;
    data_d = expire ? fpu_result : data_q;
    flags_d = expire ? fpu_flags : flags_q;
  end
  always_comb begin
    issue_ready = (state_q == IDLE) && !flush;
    busy = state_q != IDLE;
    wb_en = (state_q == WB) && !flush;
    flags_we = (state_q == WB) && !flush;
    wb_rd = rd_q;
    wb_data = data_q;
    flags_out = flags_q;
    rf_rs1 = rs1_q;
    rf_rs2 = rs2_q;
    fpu_funct7 = f7_q;
    fpu_frm = frm_q;
    illegal_op = ill_q;
  end
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed stimulus with a queue-based writeback/illegal scoreboard
module tb_fpu_sequencer;
  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } exp_t;
  logic clk, n_rst, issue_valid, issue_ready, flush;
  logic [6:0] issue_funct7, fpu_funct7;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, rf_rs1, rf_rs2, fpu_flags, wb_rd, flags_out;
  logic [2:0] issue_rm, fcsr_frm, fpu_frm;
  logic [31:0] fpu_result, wb_data;
  logic wb_en, flags_we, illegal_op, busy;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  fpu_sequencer dut (
    .clk(clk), .n_rst(n_rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct7(issue_funct7), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rm(issue_rm), .fcsr_frm(fcsr_frm), .flush(flush),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .fpu_funct7(fpu_funct7), .fpu_frm(fpu_frm),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flags_we(flags_we), .flags_out(flags_out),
    .illegal_op(illegal_op), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (n_rst === 1'b1 && (wb_en === 1'b1 || illegal_op === 1'b1)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, wb_en, illegal_op}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(illegal_op), 32'(e.ill));
        if (!e.ill) begin
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
          chk("flags_we", 32'(flags_we), 32'd1);
          chk("flags_out", 32'(flags_out), 32'(e.flags));
        end else begin
          chk("ill_no_flags_we", 32'(flags_we), 32'd0);
        end
      end
    end
  end
  task automatic issue(input logic [6:0] f7, input logic [4:0] r1, r2, rd, input logic [2:0] rm, frm,
                       input logic [31:0] res, input logic [4:0] fl, input bit push_wb, push_ill);
    exp_t x;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_funct7 = f7;
    issue_rs1 = r1;
    issue_rs2 = r2;
    issue_rd = rd;
    issue_rm = rm;
    fcsr_frm = frm;
    fpu_result = res;
    fpu_flags = fl;
    x.ill = push_ill;
    x.rd = rd;
    x.data = res;
    x.flags = fl;
    if (push_wb || push_ill) q.push_back(x);
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask
  task automatic run_op(input int lat, input logic [4:0] r1, r2, input logic [2:0] frm, input logic [6:0] f7);
    int low = 0;
    int bad = 0;
    bit seen = 0;
    for (int i = 1; i <= lat + 4 && !seen; i++) begin
      @(negedge clk);
      if (!issue_ready) low++;
      if (wb_en) begin
        seen = 1;
        chk("wb_latency", 32'(i), 32'(lat + 1));
      end else if (rf_rs1 !== r1 || rf_rs2 !== r2 || fpu_frm !== frm || fpu_funct7 !== f7 || busy !== 1'b1) begin
        bad++;
      end
    end
    chk("wb_seen", 32'(seen), 32'd1);
    chk("exec_selects_bad", 32'(bad), 32'd0);
    chk("ready_low_cycles", 32'(low), 32'(lat + 1));
    @(negedge clk);
    chk("ready_after_wb", 32'(issue_ready), 32'd1);
    chk("idle_after_wb", 32'(busy), 32'd0);
  endtask
  task automatic check_illegal();
    @(negedge clk);
    chk("illegal_pulse", 32'(illegal_op), 32'd1);
    chk("illegal_ready", 32'(issue_ready), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("illegal_one_cycle", 32'(illegal_op), 32'd0);
    chk("illegal_no_wb", {30'd0, wb_en, flags_we}, 32'd0);
    chk("illegal_still_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int wb_seen;
    n_rst = 1'b0;
    issue_valid = 1'b0;
    flush = 1'b0;
    issue_funct7 = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_rd = '0;
    issue_rm = '0;
    fcsr_frm = '0;
    fpu_result = '0;
    fpu_flags = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {29'd0, wb_en, flags_we, illegal_op}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fields", {rf_rs1, rf_rs2, wb_rd, fpu_funct7, fpu_frm, flags_out}, 32'd0);
    n_rst = 1'b1;
    issue(7'b0000000, 5'd1, 5'd2, 5'd3, 3'b000, 3'b000, 32'h40400000, 5'b00000, 1, 0);
    run_op(3, 5'd1, 5'd2, 3'b000, 7'b0000000);
    issue(7'b0001100, 5'd4, 5'd5, 5'd6, 3'b111, 3'b010, 32'h7f800000, 5'b01000, 1, 0);
    run_op(12, 5'd4, 5'd5, 3'b010, 7'b0001100);
    issue(7'b0000100, 5'd7, 5'd8, 5'd9, 3'b001, 3'b000, 32'hc0000000, 5'b00001, 1, 0);
    run_op(3, 5'd7, 5'd8, 3'b001, 7'b0000100);
    issue(7'b0000000, 5'd1, 5'd1, 5'd1, 3'b101, 3'b000, 32'h0, 5'b0, 0, 1);
    check_illegal();
    issue(7'b0000000, 5'd1, 5'd1, 5'd1, 3'b111, 3'b110, 32'h0, 5'b0, 0, 1);
    check_illegal();
    issue(7'b0101100, 5'd1, 5'd1, 5'd1, 3'b000, 3'b000, 32'h0, 5'b0, 0, 1);
    check_illegal();
    issue(7'b0001000, 5'd10, 5'd11, 5'd12, 3'b011, 3'b000, 32'h41000000, 5'b00001, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(issue_ready), 32'd1);
    chk("flush_idle", 32'(busy), 32'd0);
    wb_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_en || flags_we) wb_seen++;
    end
    chk("flush_no_wb", 32'(wb_seen), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_funct7 = 7'b0000000;
    issue_rm = 3'b000;
    #1 chk("flush_idle_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1 begin
      flush = 1'b0;
      issue_valid = 1'b0;
    end
    @(negedge clk);
    chk("flush_blocks_accept", 32'(busy), 32'd0);
    issue(7'b0001100, 5'd20, 5'd21, 5'd22, 3'b000, 3'b000, 32'h12345678, 5'b10000, 0, 0);
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("arst_ready", 32'(issue_ready), 32'd1);
    chk("arst_strobes", {28'd0, busy, wb_en, flags_we, illegal_op}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_fields", {rf_rs1, rf_rs2, wb_rd, fpu_funct7, fpu_frm, flags_out}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    issue(7'b0000000, 5'd13, 5'd14, 5'd15, 3'b100, 3'b000, 32'h3f800000, 5'b00001, 1, 0);
    run_op(3, 5'd13, 5'd14, 3'b100, 7'b0000000);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
